mem_stage: RTL and testbench

- Memory-access pipeline stage between the EX stage and the WB stage of the 5-stage MIPS core.
- Holds one instruction, waits for the data-SRAM response of loads issued by EX, and aligns and extends load data.
- Drops stale responses after a pipeline flush and produces the 149-bit MS→WS bus consumed by WB, plus a forwarding port back to ID.

---
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundle of the MS-stage handshake, bus, SRAM-response and forwarding signals.
// master: the environment around MS (EX, WB, data SRAM, ID). slave: mem_stage.
interface mem_stage_if #(
  parameter int ES_BUS_WD = 153,
  parameter int MS_BUS_WD = 149
);
  logic                 es_to_ms_valid;
  logic [ES_BUS_WD-1:0] es_to_ms_bus;
  logic                 ms_allowin;
  logic                 ws_allowin;
  logic                 ms_to_ws_valid;
  logic [MS_BUS_WD-1:0] ms_to_ws_bus;
  logic                 data_sram_data_ok;
  logic [31:0]          data_sram_rdata;
  logic                 ws_flush;
  logic                 ms_fwd_we;
  logic [4:0]           ms_fwd_dest;
  logic [31:0]          ms_fwd_data;
  logic                 ms_fwd_stall;
  logic                 ms_ex_eret;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata, ws_flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
           ms_fwd_we, ms_fwd_dest, ms_fwd_data, ms_fwd_stall, ms_ex_eret
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata, ws_flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
           ms_fwd_we, ms_fwd_dest, ms_fwd_data, ms_fwd_stall, ms_ex_eret
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: holds one instruction, waits for its data-SRAM
// response, aligns/extends load data, drops responses orphaned by a flush.
module mem_stage #(
  parameter int ES_BUS_WD = 153,
  parameter int MS_BUS_WD = 149,
  parameter int DISCARD_W = 2
) (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave ms_if
);
  localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;
  localparam logic [DISCARD_W-1:0] DISCARD_ONE = DISCARD_W'(1);

  logic                 ms_valid_reg;
  logic [ES_BUS_WD-1:0] ms_bus_reg;
  logic [31:0]          data_buf_reg;
  logic                 data_buf_valid_reg;
  logic [DISCARD_W-1:0] discard_cnt_reg;
  logic [DISCARD_W-1:0] discard_cnt_next;

  // Fields of the held instruction
  logic        mem_req;
  logic [2:0]  ld_type;
  logic        eret;
  logic        res_from_cp0;
  logic        ex;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic [1:0]  addr_lo;

  assign mem_req      = ms_bus_reg[152];
  assign ld_type      = ms_bus_reg[151:149];
  assign eret         = ms_bus_reg[116];
  assign res_from_cp0 = ms_bus_reg[108];
  assign ex           = ms_bus_reg[75];
  assign gr_we        = ms_bus_reg[69];
  assign dest         = ms_bus_reg[68:64];
  assign result       = ms_bus_reg[63:32];
  assign addr_lo      = result[1:0];

  // Handshake and sub-state decode
  logic in_wait;
  logic resp;
  logic ready_go;
  logic allowin;
  logic accept;
  logic flush;

  assign flush    = ms_if.ws_flush;
  assign in_wait  = ms_valid_reg & mem_req & ~data_buf_valid_reg;
  // A response is only ours once every orphaned response has drained
  assign resp     = ms_if.data_sram_data_ok & (discard_cnt_reg == '0);
  assign ready_go = ~in_wait | resp;
  assign allowin  = ~ms_valid_reg | (ready_go & ms_if.ws_allowin);
  assign accept   = ms_if.es_to_ms_valid & allowin;

  // Load data: buffered copy once captured, otherwise the live response
  logic [31:0] ld_word;
  logic [7:0]  ld_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign ld_word = data_buf_valid_reg ? data_buf_reg : ms_if.data_sram_rdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign ld_byte[gi] = ld_word[8*gi +: 8];
  end

  assign sel_byte = ld_byte[addr_lo];
  assign sel_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

  // Align and extend according to the load type; unknown codes behave as lw
  always_comb begin
    load_result = ld_word;
    case (ld_type)
      3'b001:  load_result = {{24{sel_byte[7]}}, sel_byte};
      3'b010:  load_result = {24'h0, sel_byte};
      3'b011:  load_result = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_result = {16'h0, sel_half};
      default: load_result = ld_word;
    endcase
  end

  assign final_result = mem_req ? load_result : result;

  assign ms_if.ms_allowin     = allowin;
  assign ms_if.ms_to_ws_valid = ms_valid_reg & ready_go;
  assign ms_if.ms_to_ws_bus   = {ms_bus_reg[148:64], final_result, ms_bus_reg[31:0]};
  assign ms_if.ms_fwd_we      = ms_valid_reg & gr_we & ~ex;
  assign ms_if.ms_fwd_dest    = dest;
  assign ms_if.ms_fwd_data    = final_result;
  assign ms_if.ms_fwd_stall   = ms_valid_reg & (res_from_cp0 | (in_wait & ~resp));
  assign ms_if.ms_ex_eret     = ms_valid_reg & (ex | eret);

  // Discard counter: drain on data_ok first, then count a load killed while waiting
  always_comb begin
    discard_cnt_next = discard_cnt_reg;
    if (ms_if.data_sram_data_ok && (discard_cnt_reg != '0)) begin
      discard_cnt_next = discard_cnt_reg - DISCARD_ONE;
    end
    if (flush && in_wait && !resp && (discard_cnt_next != DISCARD_MAX)) begin
      discard_cnt_next = discard_cnt_next + DISCARD_ONE;
    end
  end

  // Valid bit: flush wins over accept; an empty or departing slot drops valid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_reg <= 1'b0;
    end else if (flush) begin
      ms_valid_reg <= 1'b0;
    end else if (accept) begin
      ms_valid_reg <= 1'b1;
    end else if (allowin) begin
      ms_valid_reg <= 1'b0;
    end
  end

  // Instruction bus register, loaded only on a real accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_bus_reg <= '0;
    end else if (accept && !flush) begin
      ms_bus_reg <= ms_if.es_to_ms_bus;
    end
  end

  // Load data buffer: captured once per instruction so a WB stall holds it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_buf_valid_reg <= 1'b0;
      data_buf_reg       <= 32'h0;
    end else if (flush || allowin) begin
      data_buf_valid_reg <= 1'b0;
    end else if (in_wait && resp) begin
      data_buf_valid_reg <= 1'b1;
      data_buf_reg       <= ms_if.data_sram_rdata;
    end
  end

  // Stale-response discard counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard_cnt_reg <= '0;
    end else begin
      discard_cnt_reg <= discard_cnt_next;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: load-extension vector table plus hand-written flush,
// stall, reset and back-to-back sequences, checked against a WB scoreboard.
module tb_mem_stage;
  logic clk;
  logic resetn;

  mem_stage_if #(.ES_BUS_WD(153), .MS_BUS_WD(149)) ms_if ();

  mem_stage #(.ES_BUS_WD(153), .MS_BUS_WD(149), .DISCARD_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ms_if  (ms_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [31:0] pc;
    logic [4:0]  dest;
  } exp_t;

  typedef struct {
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] pc_ctr = 32'hBFC0_0000;

  // Values sampled at the falling edge of the cycle that just ended
  logic s_valid, s_allowin, s_stall, s_fwd_we, s_ex_eret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [152:0] mk_bus(input logic mem_req, input logic [2:0] lt,
                                          input logic gr_we, input logic [4:0] dest,
                                          input logic [31:0] result, input logic [31:0] pc,
                                          input logic ex, input logic rfc0);
    logic [152:0] b;
    b           = '0;
    b[152]      = mem_req;
    b[151:149]  = lt;
    b[148:117]  = 32'h5A5A_0000 ^ pc;
    b[108]      = rfc0;
    b[75]       = ex;
    b[69]       = gr_we;
    b[68:64]    = dest;
    b[63:32]    = result;
    b[31:0]     = pc;
    return b;
  endfunction

  // One clock cycle: sample at the falling edge, score WB transfers, return just after the rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_valid   = ms_if.ms_to_ws_valid;
    s_allowin = ms_if.ms_allowin;
    s_stall   = ms_if.ms_fwd_stall;
    s_fwd_we  = ms_if.ms_fwd_we;
    s_ex_eret = ms_if.ms_ex_eret;
    if (ms_if.ms_to_ws_valid && ms_if.ws_allowin) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got result 0x%08h pc 0x%08h expected no transfer",
                 ms_if.ms_to_ws_bus[63:32], ms_if.ms_to_ws_bus[31:0]);
      end else begin
        e = sb.pop_front();
        $display("WB pc=0x%08h result=0x%08h (want 0x%08h)",
                 ms_if.ms_to_ws_bus[31:0], ms_if.ms_to_ws_bus[63:32], e.result);
        chk("wb_result", ms_if.ms_to_ws_bus[63:32], e.result);
        chk("wb_pc", ms_if.ms_to_ws_bus[31:0], e.pc);
        chk("wb_dest", {27'h0, ms_if.ms_to_ws_bus[68:64]}, {27'h0, e.dest});
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] next_pc();
    pc_ctr = pc_ctr + 32'd4;
    return pc_ctr;
  endfunction

  // Issue a load, wait 'delay' cycles, then deliver the response
  task automatic run_load(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] exp, input int delay);
    logic [31:0] pc;
    pc = next_pc();
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(1'b1, lt, 1'b1, 5'd8, addr, pc, 1'b0, 1'b0);
    tick();
    chk({tag, "_accept"}, {31'h0, s_allowin}, 32'h1);
    ms_if.es_to_ms_valid = 1'b0;
    sb.push_back('{result: exp, pc: pc, dest: 5'd8});
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({tag, "_wait_stall"}, {31'h0, s_stall}, 32'h1);
      chk({tag, "_wait_valid"}, {31'h0, s_valid}, 32'h0);
    end
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = rd;
    tick();
    chk({tag, "_resp_stall"}, {31'h0, s_stall}, 32'h0);
    chk({tag, "_resp_valid"}, {31'h0, s_valid}, 32'h1);
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
  endtask

  initial begin
    logic [31:0] pc;

    vecs[0] = '{3'b000, 2'd0, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{3'b001, 2'd3, 32'h80AA_55CC, 32'hFFFF_FF80};
    vecs[2] = '{3'b100, 2'd2, 32'h80AA_55CC, 32'h0000_80AA};
    vecs[3] = '{3'b011, 2'd0, 32'h80AA_55CC, 32'h0000_55CC};
    vecs[4] = '{3'b001, 2'd0, 32'h80AA_55CC, 32'hFFFF_FFCC};
    vecs[5] = '{3'b010, 2'd1, 32'h80AA_55CC, 32'h0000_0055};
    vecs[6] = '{3'b010, 2'd3, 32'h80AA_55CC, 32'h0000_0080};
    vecs[7] = '{3'b011, 2'd2, 32'h80AA_55CC, 32'hFFFF_80AA};
    vecs[8] = '{3'b101, 2'd2, 32'h80AA_55CC, 32'h80AA_55CC};
    vecs[9] = '{3'b100, 2'd0, 32'h80AA_55CC, 32'h0000_55CC};

    resetn                  = 1'b0;
    ms_if.es_to_ms_valid    = 1'b0;
    ms_if.es_to_ms_bus      = '0;
    ms_if.ws_allowin        = 1'b1;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    ms_if.ws_flush          = 1'b0;

    // Reset state
    tick();
    chk("rst_valid",   {31'h0, s_valid},   32'h0);
    chk("rst_allowin", {31'h0, s_allowin}, 32'h1);
    chk("rst_fwd_we",  {31'h0, s_fwd_we},  32'h0);
    chk("rst_stall",   {31'h0, s_stall},   32'h0);
    chk("rst_ex_eret", {31'h0, s_ex_eret}, 32'h0);
    resetn = 1'b1;
    tick();

    // lw with response two cycles after accept
    run_load("lw_delay2", 3'b000, 32'h0000_1000, 32'h1234_5678, 32'h1234_5678, 2);

    // Extension table, response in the accept+1 cycle
    foreach (vecs[i]) begin
      run_load($sformatf("vec%0d", i), vecs[i].ld_type, {30'h400, vecs[i].addr_lo},
               vecs[i].rdata, vecs[i].exp, 0);
    end

    // Flush during WAIT: the orphaned response must be dropped
    pc = next_pc();
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd9, 32'h2000, pc, 1'b0, 1'b0);
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    ms_if.ws_flush       = 1'b1;
    tick();
    chk("flush_valid", {31'h0, s_valid}, 32'h0);
    ms_if.ws_flush = 1'b0;
    pc = next_pc();
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd10, 32'h3000, pc, 1'b0, 1'b0);
    tick();
    chk("flush_new_accept", {31'h0, s_allowin}, 32'h1);
    ms_if.es_to_ms_valid = 1'b0;
    sb.push_back('{result: 32'h0000_BEEF, pc: pc, dest: 5'd10});
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'hDEAD_0000;
    tick();
    chk("flush_stale_drop", {31'h0, s_valid}, 32'h0);
    chk("flush_stale_stall", {31'h0, s_stall}, 32'h1);
    ms_if.data_sram_rdata = 32'h0000_BEEF;
    tick();
    chk("flush_second_valid", {31'h0, s_valid}, 32'h1);
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;

    // WB stall: data held across repeated data_ok, delivered exactly once
    ms_if.ws_allowin = 1'b0;
    pc = next_pc();
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd11, 32'h4000, pc, 1'b0, 1'b0);
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    sb.push_back('{result: 32'hCAFE_F00D, pc: pc, dest: 5'd11});
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'hCAFE_F00D;
    tick();
    chk("stall_allowin_resp", {31'h0, s_allowin}, 32'h0);
    ms_if.data_sram_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_allowin_hold", {31'h0, s_allowin}, 32'h0);
    end
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    ms_if.ws_allowin        = 1'b1;
    tick();
    chk("stall_release_valid", {31'h0, s_valid}, 32'h1);
    tick();
    chk("stall_once", {31'h0, s_valid}, 32'h0);

    // Reset while waiting, with a pending discard count
    pc = next_pc();
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd12, 32'h5000, pc, 1'b0, 1'b0);
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    ms_if.ws_flush       = 1'b1;
    tick();
    ms_if.ws_flush = 1'b0;
    pc = next_pc();
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(1'b1, 3'b000, 1'b1, 5'd13, 32'h6000, pc, 1'b0, 1'b0);
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    resetn = 1'b0;
    tick();
    chk("midrst_valid",   {31'h0, s_valid},   32'h0);
    chk("midrst_allowin", {31'h0, s_allowin}, 32'h1);
    resetn = 1'b1;
    tick();
    chk("postrst_allowin", {31'h0, s_allowin}, 32'h1);
    run_load("postrst_lw", 3'b000, 32'h7000, 32'h0F0F_1234, 32'h0F0F_1234, 0);

    // Back-to-back: ALU op then load, one per cycle to WB
    pc = next_pc();
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(1'b0, 3'b000, 1'b1, 5'd14, 32'h0000_0005, pc, 1'b0, 1'b0);
    tick();
    sb.push_back('{result: 32'h0000_0005, pc: pc, dest: 5'd14});
    pc = next_pc();
    ms_if.es_to_ms_bus = mk_bus(1'b1, 3'b000, 1'b1, 5'd15, 32'h8000, pc, 1'b0, 1'b0);
    tick();
    chk("b2b_add_valid",   {31'h0, s_valid},   32'h1);
    chk("b2b_add_fwd_we",  {31'h0, s_fwd_we},  32'h1);
    chk("b2b_lw_accept",   {31'h0, s_allowin}, 32'h1);
    sb.push_back('{result: 32'h0BAD_F00D, pc: pc, dest: 5'd15});
    ms_if.es_to_ms_valid    = 1'b0;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h0BAD_F00D;
    tick();
    chk("b2b_lw_valid",  {31'h0, s_valid},  32'h1);
    chk("b2b_lw_fwd_we", {31'h0, s_fwd_we}, 32'h1);
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;

    // Exception + CP0 read: no forwarding write, ID stall, EX told to suppress stores
    pc = next_pc();
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk_bus(1'b0, 3'b000, 1'b1, 5'd16, 32'h0000_0077, pc, 1'b1, 1'b1);
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    sb.push_back('{result: 32'h0000_0077, pc: pc, dest: 5'd16});
    tick();
    chk("ex_ex_eret", {31'h0, s_ex_eret}, 32'h1);
    chk("ex_fwd_we",  {31'h0, s_fwd_we},  32'h0);
    chk("ex_stall",   {31'h0, s_stall},   32'h1);
    tick();

    chk("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
